// File: rtl/pipe_rbs.sv
// ---------------------------------------------------------------------------
// pipe_rbs -- bit-serial pipelined ripple-borrow subtractor
//
// Computes {Bout, Diff} = A - B - Bin (unsigned, modulo 2^WIDTH, wrap shown
// only in Bout) using one borrow cell per pipeline stage. Stage k resolves
// difference bit k from the operand bits carried forward by stage k-1 and the
// borrow that stage k-1 registered. The result leaves the last stage WIDTH
// cycles after the operands are accepted. All stages move together under a
// single advance enable, so a stalled output freezes the whole pipe.
//
// Parameters
//   WIDTH      operand width and pipeline depth in stages (must be >= 2)
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst        in   synchronous active-high reset, wins over stall/advance
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow-in
//   In_valid   in   1      A/B/Bin valid this cycle
//   In_ready   out  1      operand set accepted this cycle (= advance)
//   Out_ready  in   1      consumer takes the result this cycle
//   Diff       out  WIDTH  A - B - Bin modulo 2^WIDTH
//   Bout       out  1      borrow-out (A < B + Bin)
//   Out_valid  out  1      Diff/Bout valid this cycle
// ---------------------------------------------------------------------------
module pipe_rbs #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Out_valid
);

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bw);
        logic d;
        logic bo;
        d  = a ^ b ^ bw;
        bo = (~a & b) | (~(a ^ b) & bw);
        return {bo, d};
    endfunction

    // Per-stage registers. r_diff[k] holds difference bits 0..k (upper bits
    // stay zero). r_a/r_b[k] hold the operand bits still to be consumed
    // (bits k+1 and up); consumed bits are cleared as they are used. The last
    // stage has no operand bits left, hence only WIDTH-1 operand registers.
    logic             r_valid  [WIDTH];
    logic [WIDTH-1:0] r_diff   [WIDTH];
    logic             r_borrow [WIDTH];
    logic [WIDTH-1:0] r_a      [WIDTH-1];
    logic [WIDTH-1:0] r_b      [WIDTH-1];

    logic             w_adv;
    logic             w_d  [WIDTH];
    logic             w_bo [WIDTH];

    // The pipe advances unless a valid result is waiting for a consumer that
    // is not ready. A bubble at the output never blocks.
    assign w_adv    = ~(r_valid[WIDTH-1] & ~Out_ready);
    assign In_ready = w_adv;

    // Borrow cells for every stage.
    always_comb begin
        logic [1:0] w_cell;
        // NOTE: combinational logic uses blocking '=' and gives every output
        // a value on every path, so no latch is inferred.
        w_cell  = sub_cell(A[0], B[0], Bin);
        w_bo[0] = w_cell[1];
        w_d[0]  = w_cell[0];
        for (int k = 1; k < WIDTH; k++) begin
            w_cell  = sub_cell(r_a[k-1][k], r_b[k-1][k], r_borrow[k-1]);
            w_bo[k] = w_cell[1];
            w_d[k]  = w_cell[0];
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking '<=' so every stage samples
        // the previous stage's value from before this edge.
        if (Rst) begin
            for (int k = 0; k < WIDTH; k++) begin
                r_valid[k]  <= 1'b0;
                r_diff[k]   <= '0;
                r_borrow[k] <= 1'b0;
            end
            for (int k = 0; k < WIDTH - 1; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_adv) begin
            // Stage 0: with the pipe advancing, In_ready is 1, so the valid
            // tag is simply In_valid; In_valid=0 injects a bubble.
            r_valid[0]  <= In_valid;
            r_diff[0]   <= {{(WIDTH-1){1'b0}}, w_d[0]};
            r_borrow[0] <= w_bo[0];
            r_a[0]      <= {A[WIDTH-1:1], 1'b0};
            r_b[0]      <= {B[WIDTH-1:1], 1'b0};

            for (int k = 1; k < WIDTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_diff[k]    <= r_diff[k-1];
                r_diff[k][k] <= w_d[k];
                r_borrow[k]  <= w_bo[k];
            end

            for (int k = 1; k < WIDTH - 1; k++) begin
                r_a[k]    <= r_a[k-1];
                r_a[k][k] <= 1'b0;
                r_b[k]    <= r_b[k-1];
                r_b[k][k] <= 1'b0;
            end
        end
        // Otherwise the pipe is stalled and every register holds.
    end

    // Outputs come straight from the final-stage registers.
    assign Diff      = r_diff[WIDTH-1];
    assign Bout      = r_borrow[WIDTH-1];
    assign Out_valid = r_valid[WIDTH-1];

endmodule

// File: tb/tb_pipe_rbs.sv
// ---------------------------------------------------------------------------
// tb_pipe_rbs -- self-checking bench for pipe_rbs (WIDTH = 4)
//
// A result-level model (a WIDTH-deep delay line of A-B-Bin values that moves
// whenever the output is not stalled) plus an acceptance-order queue is
// compared against the DUT on every falling edge. Directed sequences add
// literal expectations; a shuffled sweep of all 512 operand sets under random
// In_valid/Out_ready covers the arithmetic and ordering.
// ---------------------------------------------------------------------------
module tb_pipe_rbs;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         out_valid;

    pipe_rbs #(.WIDTH(W)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .A         (a),
        .B         (b),
        .Bin       (bin),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Out_ready (out_ready),
        .Diff      (diff),
        .Bout      (bout),
        .Out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 5-bit two's complement of A - B - Bin.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction

    // ---------------- behavioural model ----------------
    logic         m_v   [W] = '{default: 1'b0};
    logic [W:0]   m_res [W] = '{default: '0};
    logic [W:0]   exp_q [$];
    logic [W:0]   snap;
    logic [W:0]   got;
    logic         m_adv;
    logic         cmp_en = 1'b0;
    int           n_consumed = 0;

    always @(posedge clk) begin
        // NOTE: the model is bench-only state read by other processes at the
        // opposite edge, so blocking updates here cannot race the DUT.
        if (rst) begin
            for (int k = 0; k < W; k++) begin
                m_v[k]   = 1'b0;
                m_res[k] = '0;
            end
            exp_q.delete();
        end else begin
            m_adv = !(m_v[W-1] && !out_ready);
            if (m_v[W-1] && out_ready) begin
                n_consumed++;
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("order", snap, got);
                end else begin
                    check("order_q_size", exp_q.size(), 1);
                end
            end
            if (m_adv) begin
                for (int k = W - 1; k > 0; k--) begin
                    m_v[k]   = m_v[k-1];
                    m_res[k] = m_res[k-1];
                end
                m_v[0]   = in_valid;
                m_res[0] = ref_sub(a, b, bin);
                if (in_valid) exp_q.push_back(m_res[0]);
            end
        end
    end

    // Compare process: outputs settle after the rising edge and are checked
    // on the falling edge, before the stimulus changes.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", out_valid, m_v[W-1]);
            if (m_v[W-1]) check("out_data", {bout, diff}, m_res[W-1]);
            check("in_ready", in_ready, !(m_v[W-1] && !out_ready));
            snap = {bout, diff};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input logic oi, input logic ri);
        in_valid  = v;
        a         = ai;
        b         = bi;
        bin       = ci;
        out_ready = oi;
        rst       = ri;
        #1;
    endtask

    logic [W:0] exp_b2b [3];
    logic [8:0] combo   [512];
    logic [8:0] tmp;
    int         idx;
    int         cycles;
    logic       acc;
    logic       rv;
    logic       ro;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        cmp_en = 1'b1;

        // Pin the reference arithmetic.
        check("ref_5_3_0", ref_sub(4'd5, 4'd3, 1'b0), 5'h02);
        check("ref_0_1_0", ref_sub(4'd0, 4'd1, 1'b0), 5'h1F);
        check("ref_f_f_1", ref_sub(4'hF, 4'hF, 1'b1), 5'h1F);

        // Reset state (inputs presented during reset).
        set_in(1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 1'b1);
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, 4'h0);
        check("rst_bout", bout, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();

        // Single operation: latency of exactly W cycles.
        set_in(1'b1, 4'd5, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            check("lat_valid", out_valid, (i == 4));
            if (i == 4) check("lat_data", {bout, diff}, 5'h02);
            tick();
        end

        // Back-to-back operations.
        exp_b2b = '{5'h1E, 5'h1F, 5'h1F};
        set_in(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("b2b_pre", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_data", {bout, diff}, exp_b2b[i]);
        end
        tick();
        check("b2b_post", out_valid, 1'b0);
        tick();

        // Stall with In_valid held high.
        set_in(1'b1, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd4, 4'd1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'hC, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", {bout, diff}, 5'h05);
            if (i < 3) tick();
        end
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        tick();
        check("drain1", {out_valid, bout, diff}, 6'h3F);
        tick();
        check("drain2", {out_valid, bout, diff}, 6'h20);
        tick();
        check("drain3", {out_valid, bout, diff}, 6'h23);
        tick();
        check("drain_empty", out_valid, 1'b0);

        // Alternating In_valid: Out_valid follows W cycles later.
        for (int j = 1; j <= 13; j++) begin
            if (j - 1 < 8)
                set_in(((j - 1) % 2 == 0), 4'(j), 4'(j * 3), 1'(j / 2), 1'b1, 1'b0);
            else
                set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            tick();
            check("alt_valid", out_valid, (j >= 4 && (j - 4) < 8 && ((j - 4) % 2 == 0)));
        end

        // Reset mid-flight discards everything in the pipe.
        set_in(1'b1, 4'd6, 4'd1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'hA, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 4'd2, 4'd1, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("post_rst_valid", out_valid, 1'b0);
            tick();
        end
        set_in(1'b1, 4'd8, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            check("post_rst_lat", out_valid, (i == 4));
            if (i == 4) check("post_rst_data", {bout, diff}, 5'h05);
            tick();
        end

        // Shuffled sweep of every operand set under random handshakes.
        for (int i = 0; i < 512; i++) combo[i] = 9'(i);
        for (int i = 511; i > 0; i--) begin
            idx        = $urandom_range(0, i);
            tmp        = combo[i];
            combo[i]   = combo[idx];
            combo[idx] = tmp;
        end
        n_consumed = 0;
        idx        = 0;
        cycles     = 0;
        while (idx < 512 && cycles < 20000) begin
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 9) < 7);
            set_in(rv, combo[idx][8:5], combo[idx][4:1], combo[idx][0], ro, 1'b0);
            acc = rv && !(m_v[W-1] && !ro);
            tick();
            if (acc) idx++;
            cycles++;
        end
        check("sweep_all_accepted", idx, 512);
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * W; i++) tick();
        check("sweep_queue_empty", exp_q.size(), 0);
        check("sweep_consumed", n_consumed, 512);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
